// File: rtl/cu_fsm.sv
`default_nettype none
//----------------------------------------------------------------------------
// Module   : cu_fsm
// Purpose  : Control unit for the 8-bit accumulator processor. A Moore FSM
//            that runs Fetch -> Decode -> Execute for each instruction and
//            drives every control input of the downstream DP datapath.
// Revision : 1.0 - initial release
//
// Parameters:
//   IN_EDGE  1 = IN completes on a rising edge of Enter,
//            0 = IN completes while Enter is high.
//
// Build option:
//   CU_SINGLE_STEP_EN  when defined, adds the Step input and a STEP state
//                      entered after every Execute state; STEP leaves to
//                      FETCH on a rising edge of Step.
//
// Ports:
//   Clock    in   system clock, rising edge
//   Reset    in   synchronous active-low reset
//   IR[2:0]  in   opcode (instruction bits 7:5)
//   Aeq0     in   A == 0 flag
//   Apos     in   A > 0 flag
//   Enter    in   user confirm for IN
//   Step     in   single-step advance (CU_SINGLE_STEP_EN only)
//   IRload   out  load instruction register
//   JMPmux   out  1 = PC source is IR address field
//   PCload   out  load PC
//   Meminst  out  1 = memory address from IR[4:0], 0 = from PC
//   MemWr    out  memory write enable
//   Aload    out  load accumulator A
//   Sub      out  adder mode, 1 = subtract
//   Asel     out  A source: 00 adder, 01 INPUT, 10 memory
//   Halt     out  processor halted
//   State    out  current state encoding (debug)
//----------------------------------------------------------------------------
module cu_fsm #(
  parameter bit IN_EDGE = 1'b1
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [2:0] IR,
  input  logic       Aeq0,
  input  logic       Apos,
  input  logic       Enter,
`ifdef CU_SINGLE_STEP_EN
  input  logic       Step,
`endif
  output logic       IRload,
  output logic       JMPmux,
  output logic       PCload,
  output logic       Meminst,
  output logic       MemWr,
  output logic       Aload,
  output logic       Sub,
  output logic [1:0] Asel,
  output logic       Halt,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    START  = 4'd0,
    FETCH  = 4'd1,
    DECODE = 4'd2,
    LOAD   = 4'd3,
    STORE  = 4'd4,
    ADD    = 4'd5,
    SUB    = 4'd6,
    IN     = 4'd7,
    JZ     = 4'd8,
    JPOS   = 4'd9,
    HALT   = 4'd10
`ifdef CU_SINGLE_STEP_EN
    ,
    STEP   = 4'd11
`endif
  } state_t;

`ifdef CU_SINGLE_STEP_EN
  localparam state_t EXEC_NEXT = STEP;
`else
  localparam state_t EXEC_NEXT = FETCH;
`endif

  state_t state_q;
  state_t state_d;
  logic   enter_q;   // Enter from the previous cycle, for edge detection
  logic   in_done;

  // Enter is tracked every cycle, so an Enter already high when IN is
  // entered shows no edge and cannot complete the instruction.
  assign in_done = IN_EDGE ? (Enter & ~enter_q) : Enter;

`ifdef CU_SINGLE_STEP_EN
  logic step_q;
  logic step_rise;
  assign step_rise = Step & ~step_q;

  always_ff @(posedge Clock) begin
    if (!Reset) step_q <= 1'b0;
    else        step_q <= Step;
  end
`endif

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q <= START;
      enter_q <= 1'b0;
    end else begin
      state_q <= state_d;
      enter_q <= Enter;
    end
  end

  always_comb begin
    state_d = START;
    IRload  = 1'b0;
    JMPmux  = 1'b0;
    PCload  = 1'b0;
    Meminst = 1'b0;
    MemWr   = 1'b0;
    Aload   = 1'b0;
    Sub     = 1'b0;
    Asel    = 2'b00;
    Halt    = 1'b0;

    case (state_q)
      START: state_d = FETCH;

      FETCH: begin
        IRload  = 1'b1;
        PCload  = 1'b1;
        state_d = DECODE;
      end

      DECODE: begin
        Meminst = 1'b1;
        case (IR)
          3'b000:  state_d = LOAD;
          3'b001:  state_d = STORE;
          3'b010:  state_d = ADD;
          3'b011:  state_d = SUB;
          3'b100:  state_d = IN;
          3'b101:  state_d = JZ;
          3'b110:  state_d = JPOS;
          default: state_d = HALT;
        endcase
      end

      LOAD: begin
        Meminst = 1'b1;
        Asel    = 2'b10;
        Aload   = 1'b1;
        state_d = EXEC_NEXT;
      end

      STORE: begin
        Meminst = 1'b1;
        MemWr   = 1'b1;
        state_d = EXEC_NEXT;
      end

      ADD: begin
        Meminst = 1'b1;
        Aload   = 1'b1;
        state_d = EXEC_NEXT;
      end

      SUB: begin
        Meminst = 1'b1;
        Sub     = 1'b1;
        Aload   = 1'b1;
        state_d = EXEC_NEXT;
      end

      IN: begin
        Asel    = 2'b01;
        Aload   = in_done;
        state_d = in_done ? EXEC_NEXT : IN;
      end

      JZ: begin
        JMPmux  = 1'b1;
        PCload  = Aeq0;
        state_d = EXEC_NEXT;
      end

      JPOS: begin
        JMPmux  = 1'b1;
        PCload  = Apos;
        state_d = EXEC_NEXT;
      end

      HALT: begin
        Halt    = 1'b1;
        state_d = HALT;
      end

`ifdef CU_SINGLE_STEP_EN
      STEP: state_d = step_rise ? FETCH : STEP;
`endif

      // Unused encodings recover to START.
      default: state_d = START;
    endcase
  end

  assign State = state_q;

endmodule
`default_nettype wire

// File: tb/tb_cu_fsm.sv
`default_nettype none
//----------------------------------------------------------------------------
// Module   : tb_cu_fsm
// Purpose  : Directed self-checking bench for cu_fsm (default build,
//            IN_EDGE = 1). Outputs are sampled 1 time unit after each
//            rising clock edge.
// Revision : 1.0 - initial release
//----------------------------------------------------------------------------
module tb_cu_fsm;

  logic       Clock;
  logic       Reset;
  logic [2:0] IR;
  logic       Aeq0;
  logic       Apos;
  logic       Enter;
  logic       IRload, JMPmux, PCload, Meminst, MemWr, Aload, Sub, Halt;
  logic [1:0] Asel;
  logic [3:0] State;

  int checks = 0;
  int errors = 0;

  // Control vector: {IRload, JMPmux, PCload, Meminst, MemWr, Aload, Sub, Asel, Halt}
  localparam logic [9:0] C_NONE   = 10'b0000000000;
  localparam logic [9:0] C_FETCH  = 10'b1010000000;
  localparam logic [9:0] C_DECODE = 10'b0001000000;
  localparam logic [9:0] C_LOAD   = 10'b0001010100;
  localparam logic [9:0] C_STORE  = 10'b0001100000;
  localparam logic [9:0] C_ADD    = 10'b0001010000;
  localparam logic [9:0] C_SUB    = 10'b0001011000;
  localparam logic [9:0] C_INWAIT = 10'b0000000010;
  localparam logic [9:0] C_INDONE = 10'b0000010010;
  localparam logic [9:0] C_JTAKEN = 10'b0110000000;
  localparam logic [9:0] C_JNOT   = 10'b0100000000;
  localparam logic [9:0] C_HALT   = 10'b0000000001;

  logic [9:0] ctl;
  assign ctl = {IRload, JMPmux, PCload, Meminst, MemWr, Aload, Sub, Asel, Halt};

  cu_fsm #(.IN_EDGE(1'b1)) dut (
    .Clock   (Clock),
    .Reset   (Reset),
    .IR      (IR),
    .Aeq0    (Aeq0),
    .Apos    (Apos),
    .Enter   (Enter),
    .IRload  (IRload),
    .JMPmux  (JMPmux),
    .PCload  (PCload),
    .Meminst (Meminst),
    .MemWr   (MemWr),
    .Aload   (Aload),
    .Sub     (Sub),
    .Asel    (Asel),
    .Halt    (Halt),
    .State   (State)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic expect_st(input string tag, input logic [3:0] st, input logic [9:0] c);
    check({tag, ".state"}, 32'(State), 32'(st));
    check({tag, ".ctl"}, 32'(ctl), 32'(c));
  endtask

  initial begin
    Reset = 1'b0; IR = 3'b100; Aeq0 = 1'b0; Apos = 1'b0; Enter = 1'b0;

    // 1: reset and start-up
    tick(); tick();
    expect_st("reset", 4'd0, C_NONE);
    Reset = 1'b1;
    tick(); expect_st("fetch0", 4'd1, C_FETCH);
    tick(); expect_st("decode0", 4'd2, C_DECODE);

    // 2: IN waits for a rising edge of Enter
    tick(); expect_st("in_wait0", 4'd7, C_INWAIT);
    for (int i = 0; i < 5; i++) begin
      tick(); expect_st("in_wait", 4'd7, C_INWAIT);
    end
    Enter = 1'b1; #1;
    expect_st("in_done", 4'd7, C_INDONE);
    tick(); expect_st("in_fetch", 4'd1, C_FETCH);
    tick(); expect_st("in2_decode", 4'd2, C_DECODE);
    tick(); expect_st("in2_held_high", 4'd7, C_INWAIT);
    tick(); expect_st("in2_held_high2", 4'd7, C_INWAIT);
    Enter = 1'b0;
    tick(); expect_st("in2_low", 4'd7, C_INWAIT);
    Enter = 1'b1; #1;
    expect_st("in2_done", 4'd7, C_INDONE);
    tick(); expect_st("in2_fetch", 4'd1, C_FETCH);
    Enter = 1'b0;

    // 3: STORE and SUB, 3 cycles FETCH to FETCH
    IR = 3'b001;
    tick(); expect_st("st_decode", 4'd2, C_DECODE);
    tick(); expect_st("store", 4'd4, C_STORE);
    tick(); expect_st("st_fetch", 4'd1, C_FETCH);
    IR = 3'b011;
    tick(); tick(); expect_st("sub", 4'd6, C_SUB);
    tick(); expect_st("sub_fetch", 4'd1, C_FETCH);
    IR = 3'b010;
    tick(); tick(); expect_st("add", 4'd5, C_ADD);
    tick(); expect_st("add_fetch", 4'd1, C_FETCH);
    IR = 3'b000;
    tick(); tick(); expect_st("load", 4'd3, C_LOAD);
    tick(); expect_st("load_fetch", 4'd1, C_FETCH);

    // 4: conditional jumps
    IR = 3'b101; Aeq0 = 1'b1;
    tick(); tick(); expect_st("jz_taken", 4'd8, C_JTAKEN);
    Aeq0 = 1'b0; #1;
    expect_st("jz_flag_drop", 4'd8, C_JNOT);
    tick(); expect_st("jz_fetch", 4'd1, C_FETCH);
    tick(); tick(); expect_st("jz_not", 4'd8, C_JNOT);
    tick();
    IR = 3'b110; Apos = 1'b1; Aeq0 = 1'b0;
    tick(); tick(); expect_st("jpos_taken", 4'd9, C_JTAKEN);
    tick();
    Apos = 1'b0; Aeq0 = 1'b1;
    tick(); tick(); expect_st("jpos_zero", 4'd9, C_JNOT);
    tick(); expect_st("jpos_fetch", 4'd1, C_FETCH);

    // 5: HALT is sticky until reset
    IR = 3'b111;
    tick(); tick(); expect_st("halt", 4'd10, C_HALT);
    for (int i = 0; i < 20; i++) begin
      IR = 3'($urandom_range(0, 7));
      Enter = 1'($urandom_range(0, 1));
      tick(); expect_st("halt_hold", 4'd10, C_HALT);
    end
    Reset = 1'b0;
    tick(); expect_st("halt_reset", 4'd0, C_NONE);

    // Reset in the middle of a STORE aborts it
    Enter = 1'b0; Reset = 1'b1; IR = 3'b001;
    tick(); tick(); tick(); expect_st("store2", 4'd4, C_STORE);
    Reset = 1'b0;
    tick(); expect_st("store_abort", 4'd0, C_NONE);
    tick(); expect_st("store_abort_hold", 4'd0, C_NONE);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cu_fsm.md
Name: cu_fsm

Overview:
- Control unit for the 8-bit accumulator processor. It sits directly upstream of the DP datapath.
- It consumes the opcode IR[2:0] and the status flags Aeq0/Apos from DP. It drives every DP control input.
- It sequences a Moore FSM through Fetch, Decode and Execute for each instruction.
- It provides an Enter handshake for the IN instruction and a Halt indicator.

Parameters:
- IN_EDGE, 1: 1 = IN completes on a rising edge of Enter; 0 = IN completes on Enter level high.

Ports:
- Clock  input  1  system clock; all state updates on its rising edge.
- Reset  input  1  synchronous, active-low reset; sampled on the rising edge of Clock.
- IR  input  3  opcode from DP (instruction bits 7:5).
- Aeq0  input  1  A == 0 flag from DP.
- Apos  input  1  A > 0 flag from DP.
- Enter  input  1  user confirm for IN.
- IRload  output  1  load instruction register.
- JMPmux  output  1  1 = PC source is IR address field.
- PCload  output  1  load PC.
- Meminst  output  1  1 = memory address from IR[4:0]; 0 = from PC.
- MemWr  output  1  memory write enable.
- Aload  output  1  load accumulator A.
- Sub  output  1  adder mode: 0 = add, 1 = subtract.
- Asel  output  2  A source: 00 = adder/subtractor, 01 = INPUT, 10 = memory data, 11 = reserved (never driven).
- Halt  output  1  processor halted.
- State  output  4  current state encoding, for debug.

Behaviour:
Reset and output timing
- Reset low at a rising Clock edge forces state START and clears the Enter-edge register.
- All outputs are pure functions of the state register (Moore outputs), with two exceptions:
  - PCload in JZ/JPOS depends on the flags.
  - Aload in IN depends on the Enter-complete condition.
- In START every output is 0 and Asel = 00.
- Reset asserted mid-instruction aborts that instruction. A STORE already in progress writes at most once, on the cycle it was in STORE.

State encoding
- START = 0, FETCH = 1, DECODE = 2, LOAD = 3, STORE = 4, ADD = 5, SUB = 6, IN = 7, JZ = 8, JPOS = 9, HALT = 10, STEP = 11.
- Unused codes return to START on the next edge.

Transitions
- START -> FETCH.
- FETCH: IRload = 1, PCload = 1, JMPmux = 0, Meminst = 0. -> DECODE.
- DECODE: Meminst = 1. Next state is chosen by IR:
  - 000 LOAD
  - 001 STORE
  - 010 ADD
  - 011 SUB
  - 100 IN
  - 101 JZ
  - 110 JPOS
  - 111 HALT
- LOAD: Meminst = 1, Asel = 10, Aload = 1.
- STORE: Meminst = 1, MemWr = 1.
- ADD: Meminst = 1, Asel = 00, Sub = 0, Aload = 1.
- SUB: Meminst = 1, Asel = 00, Sub = 1, Aload = 1.
- IN: Asel = 01.
  - Completion condition: rising edge of Enter (IN_EDGE = 1, using a registered previous Enter) or Enter = 1 (IN_EDGE = 0).
  - Aload = 1 only in the cycle the condition holds; the FSM then leaves IN.
  - Otherwise it holds in IN with Aload = 0.
  - An Enter already high on entry does not complete IN when IN_EDGE = 1.
- JZ: JMPmux = 1, PCload = Aeq0.
- JPOS: JMPmux = 1, PCload = Apos. When Aeq0 = 1, Apos = 0 and no jump is taken.
- After each Execute state, the next state is FETCH (or STEP when STEP_EN is defined).
- HALT: Halt = 1, all other controls 0. The FSM stays in HALT until Reset.

Timing and invariants
- Latency: 3 cycles per instruction (FETCH, DECODE, EXEC). IN takes 3 + wait cycles.
- MemWr and Aload are never both 1.
- IRload is 1 only in FETCH.

Optional Feature:
- Macro: CU_SINGLE_STEP_EN.
- When defined:
  - Adds input port Step (1 bit).
  - After every Execute state the FSM enters STEP, with all controls 0.
  - STEP -> FETCH on a rising edge of Step, using a registered previous Step cleared by Reset.
  - HALT is unaffected.
- When undefined:
  - No Step port and no STEP state; Execute -> FETCH directly.
  - Code 11 is unused.

Test Plan:
1. Reset = 0 for 2 cycles, then 1 -> all outputs 0 during reset; State = 0, then 1, then 2 on the following edges; FETCH shows IRload = PCload = 1.
2. IR = 100, Enter = 0 for 5 cycles, then 0 -> 1 -> FSM holds in IN with Asel = 01 and Aload = 0. Aload pulses exactly 1 cycle on the Enter edge, then FETCH. Enter held high into a second IN does not complete it (IN_EDGE = 1).
3. IR = 001 -> STORE cycle has Meminst = 1, MemWr = 1, Aload = 0. IR = 011 -> SUB cycle has Asel = 00, Sub = 1, Aload = 1. Each takes exactly 3 cycles from FETCH to the next FETCH.
4. IR = 101 with Aeq0 = 1 -> PCload = 1, JMPmux = 1. With Aeq0 = 0 -> PCload = 0, JMPmux = 1. IR = 110 with Apos = 1, Aeq0 = 0 -> PCload = 1. With Apos = 0 -> PCload = 0.
5. IR = 111 -> Halt = 1 and stays 1 for 20 cycles regardless of IR/Enter. Reset = 0 -> Halt = 0 and START.
6. CU_SINGLE_STEP_EN defined, IR = 000: after LOAD the FSM holds in STEP (State = 11) for 10 cycles. A Step pulse -> FETCH on the next edge.
